if_fetch_ctrl: RTL

//  Fetch stage of the 5-stage pipeline: owns the PC register, drives the synchronous instruction ROM,
//  and holds the IF/ID pipeline register. It consumes the EX-stage redirect (npc_op, pc_jump)

---
 rtl/if_fetch_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/if_fetch_ctrl.sv
// Fetch stage: owns the PC, drives the synchronous instruction ROM and holds the IF/ID register.
// Handles EX redirects (squashing wrong-path data) and buffers one returning instruction across stalls.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        npc_op,
  input  logic [31:0] pc_jump,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_inst,
  output logic        flush_id_ex,
  output logic        misalign_err
);

  logic [31:0] pc_q, pc_d;
  logic        resp_vld_q, resp_vld_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  logic        skid_vld_q, skid_vld_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_pc4_q, if_id_pc4_d;
  logic [31:0] if_id_inst_q, if_id_inst_d;
  logic        misalign_q, misalign_d;

  assign imem_addr    = pc_q;
  assign imem_en      = !rst && !stall && !npc_op;
  assign flush_id_ex  = npc_op;
  assign if_id_valid  = if_id_valid_q;
  assign if_id_pc     = if_id_pc_q;
  assign if_id_pc4    = if_id_pc4_q;
  assign if_id_inst   = if_id_inst_q;
  assign misalign_err = misalign_q;

  always_comb begin
    pc_d          = pc_q;
    resp_vld_d    = resp_vld_q;
    resp_pc_d     = resp_pc_q;
    skid_vld_d    = skid_vld_q;
    skid_pc_d     = skid_pc_q;
    skid_inst_d   = skid_inst_q;
    if_id_valid_d = if_id_valid_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_pc4_d   = if_id_pc4_q;
    if_id_inst_d  = if_id_inst_q;
    misalign_d    = misalign_q;

    if (npc_op) begin
      // Redirect wins over stall: drop in-flight and skidded wrong-path work.
      pc_d          = {pc_jump[31:2], 2'b00};
      resp_vld_d    = 1'b0;
      skid_vld_d    = 1'b0;
      if_id_valid_d = 1'b0;
      if_id_inst_d  = NOP_INST;
      if (pc_jump[1:0] != 2'b00) misalign_d = 1'b1;
    end else if (stall) begin
      resp_vld_d = 1'b0;
      if (resp_vld_q) begin
        skid_vld_d  = 1'b1;
        skid_pc_d   = resp_pc_q;
        skid_inst_d = imem_rdata;
      end
    end else begin
      pc_d       = pc_q + 32'd4;
      resp_vld_d = 1'b1;
      resp_pc_d  = pc_q;
      // A stall always clears resp_vld, so skid and response never compete here.
      if (skid_vld_q) begin
        skid_vld_d    = 1'b0;
        if_id_valid_d = 1'b1;
        if_id_pc_d    = skid_pc_q;
        if_id_pc4_d   = skid_pc_q + 32'd4;
        if_id_inst_d  = skid_inst_q;
      end else if (resp_vld_q) begin
        if_id_valid_d = 1'b1;
        if_id_pc_d    = resp_pc_q;
        if_id_pc4_d   = resp_pc_q + 32'd4;
        if_id_inst_d  = imem_rdata;
      end else begin
        if_id_valid_d = 1'b0;
        if_id_inst_d  = NOP_INST;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      resp_vld_q    <= 1'b0;
      resp_pc_q     <= '0;
      skid_vld_q    <= 1'b0;
      skid_pc_q     <= '0;
      skid_inst_q   <= '0;
      if_id_valid_q <= 1'b0;
      if_id_pc_q    <= '0;
      if_id_pc4_q   <= 32'd4;
      if_id_inst_q  <= NOP_INST;
      misalign_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      resp_vld_q    <= resp_vld_d;
      resp_pc_q     <= resp_pc_d;
      skid_vld_q    <= skid_vld_d;
      skid_pc_q     <= skid_pc_d;
      skid_inst_q   <= skid_inst_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_inst_q  <= if_id_inst_d;
      misalign_q    <= misalign_d;
    end
  end

endmodule
